// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR MAC sequencer family.
// Q1.23 sample/coefficient format, 48-bit products.
package fir_pkg;

  localparam int DATA_W = 24;
  localparam int PROD_W = 48;
  localparam int FRAC = 23;
  localparam logic [23:0] SAT_MAX = 24'h7FFFFF;
  localparam logic [23:0] SAT_MIN = 24'h800000;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_t;

  // Product width plus enough guard bits to sum taps products.
  function automatic int acc_width(input int taps);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < taps) n = i + 1;
    end
    return PROD_W + n;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, shift out fractional bits and clip to 24-bit
// signed range; flags when the clip was applied.
module fir_round_sat #(
  parameter int ACC_W = 50,
  parameter int SHIFT = 23
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [23:0]             data,
  output logic                    sat
);
  import fir_pkg::*;

  localparam logic signed [ACC_W:0] HALF =
    (ACC_W+1)'(1) << (SHIFT - 1);

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] sh;
  logic [ACC_W-DATA_W+1:0] top;

  // Round, shift, and clip when the upper bits are not a sign extension.
  always_comb begin
    sum = {acc[ACC_W-1], acc} + HALF;
    sh = sum >>> SHIFT;
    top = sh[ACC_W:DATA_W-1];
    sat = ~((&top) | (~|top));
    if (sat) data = sh[ACC_W] ? SAT_MIN : SAT_MAX;
    else data = sh[DATA_W-1:0];
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: circular sample history, one MAC per
// cycle over all taps, rounded/saturated result on valid/ready.
module fir_mac_sequencer #(
  parameter int TAPS = 100,
  parameter int DATA_W = 24,
  parameter int FRAC = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  input  logic              out_ready,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  input  logic              flush,
  output logic              busy
);
  import fir_pkg::*;

  localparam int PW = $clog2(TAPS);
  localparam int ACC_W = acc_width(TAPS);

  state_t state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] tap_cnt;
  logic [PW-1:0] rd_idx;
  logic [PW-1:0] nxt_ptr;
  logic signed [ACC_W-1:0] acc;
  logic signed [DATA_W-1:0] samp [TAPS];
  logic signed [DATA_W-1:0] coef [TAPS];
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0] rs_data;
  logic rs_sat;
  logic cfg_hit;

  assign busy = (state != IDLE);
  assign in_ready = ~busy;
  assign cfg_ready = ~busy;
  assign cfg_hit = cfg_we && (state == IDLE) &&
                   ({1'b0, cfg_addr} < 9'(TAPS));

  // History read index walks backwards from the newest sample.
  always_comb begin
    rd_idx = '0;
    if (wr_ptr >= tap_cnt) rd_idx = wr_ptr - tap_cnt;
    else rd_idx = PW'({1'b0, wr_ptr} + (PW+1)'(TAPS) - {1'b0, tap_cnt});
    prod = samp[rd_idx] * coef[tap_cnt];
  end

  // Write slot for the next sample; a flush restarts the ring at 0.
  always_comb begin
    if (flush) nxt_ptr = PW'(1);
    else if (wr_ptr == PW'(TAPS - 1)) nxt_ptr = '0;
    else nxt_ptr = wr_ptr + PW'(1);
  end

  fir_round_sat #(
    .ACC_W(ACC_W),
    .SHIFT(FRAC)
  ) u_round_sat (
    .acc (acc),
    .data(rs_data),
    .sat (rs_sat)
  );

  // Coefficients survive reset; software reloads them while idle.
  always_ff @(posedge clk) begin
    if (cfg_hit) coef[cfg_addr[PW-1:0]] <= cfg_data;
  end

  // Sequencer: accept, accumulate all taps, round, hand off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      tap_cnt <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
      for (int i = 0; i < TAPS; i++) samp[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush) begin
            for (int i = 0; i < TAPS; i++) samp[i] <= '0;
            wr_ptr <= '0;
          end
          if (in_valid) begin
            wr_ptr <= nxt_ptr;
            samp[nxt_ptr] <= in_data;
            acc <= '0;
            tap_cnt <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
          tap_cnt <= tap_cnt + PW'(1);
          if (tap_cnt == PW'(TAPS - 1)) state <= ROUND;
        end
        ROUND: begin
          out_data <= rs_data;
          out_sat <= rs_sat;
          out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer with TAPS=4: convolution model,
// scoreboard on every output handshake, directed and random traffic.
module tb_fir_mac_sequencer;

  localparam int TAPS = 4;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, out_valid, out_sat, out_ready;
  logic in_ready, cfg_ready, busy, cfg_we, flush;
  logic [23:0] in_data, out_data, cfg_data;
  logic [7:0] cfg_addr;

  typedef struct {
    logic [23:0] d;
    logic s;
  } exp_t;

  int checks = 0;
  int failures = 0;
  longint coef_m [TAPS];
  longint hist [TAPS];
  exp_t exp_q [$];
  exp_t cmp_e;
  logic [23:0] last_out;
  logic last_sat;
  int rdy_mode = 1;
  logic [23:0] cset [4] = '{24'h400000, 24'h200000, 24'h100000, 24'h080000};
  logic [23:0] imp_exp [5] = '{24'h200000, 24'h100000, 24'h080000,
                               24'h040000, 24'h000000};

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .TAPS(TAPS),
    .DATA_W(24),
    .FRAC(23)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sat(out_sat),
    .out_ready(out_ready),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .flush(flush),
    .busy(busy)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // y[n] = sum_k c[k]*x[n-k], rounded at bit 23 and clipped.
  function automatic exp_t model_out();
    longint y, r;
    exp_t e;
    y = 0;
    for (int k = 0; k < TAPS; k++) y += coef_m[k] * hist[k];
    r = (y + 64'sd4194304) >>> 23;
    if (r > 64'sd8388607) e = '{24'h7FFFFF, 1'b1};
    else if (r < -64'sd8388608) e = '{24'h800000, 1'b1};
    else e = '{r[23:0], 1'b0};
    return e;
  endfunction

  // Sink: choose out_ready, then check any output that will handshake.
  always @(negedge clk) begin
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (reset === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0h required=none", out_data);
      end else begin
        cmp_e = exp_q.pop_front();
        chk("out_data", out_data, cmp_e.d);
        chk("out_sat", out_sat, cmp_e.s);
        last_out = out_data;
        last_sat = out_sat;
      end
    end
  end

  task automatic op(input bit do_s, input logic [23:0] x, input bit do_c,
                    input logic [7:0] a, input logic [23:0] d, input bit do_f);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL op_timeout actual=busy required=idle");
    end
    in_valid = do_s;
    in_data = x;
    cfg_we = do_c;
    cfg_addr = a;
    cfg_data = d;
    flush = do_f;
    if (do_f) for (int k = 0; k < TAPS; k++) hist[k] = 0;
    if (do_c && a < 8'd4) coef_m[a] = $signed(d);
    if (do_s) begin
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = $signed(x);
      exp_q.push_back(model_out());
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
  endtask

  task automatic impulse_seq(input string tag);
    for (int i = 0; i < 5; i++) begin
      op(1, (i == 0) ? 24'h400000 : 24'h000000, 0, 8'd0, 24'd0, 0);
      drain();
      chk({tag, "_data"}, last_out, imp_exp[i]);
      chk({tag, "_sat"}, last_sat, 0);
    end
  endtask

  initial begin
    int n;
    logic [23:0] hold;
    int r;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    flush = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      hist[k] = 0;
      coef_m[k] = 0;
    end
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) op(0, 0, 1, 8'(i), cset[i], 0);
    op(0, 0, 0, 0, 0, 1);
    impulse_seq("impulse");

    op(1, 24'h000010, 0, 0, 0, 0);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk("t_in_ready", in_ready, (j >= 6) ? 1 : 0);
      chk("t_cfg_ready", cfg_ready, (j >= 6) ? 1 : 0);
      chk("t_out_valid", out_valid, (j == 5) ? 1 : 0);
    end
    drain();

    rdy_mode = 0;
    op(1, 24'h400000, 0, 0, 0, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_rise", out_valid, 1);
    hold = out_data;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 24'h123456;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, hold);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();
    for (int j = 0; j < 3; j++) op(1, 24'h000000, 0, 0, 0, 0);
    drain();

    op(0, 0, 0, 0, 0, 1);
    op(1, 24'h400000, 0, 0, 0, 0);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 8'd0;
    cfg_data = 24'h000000;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    drain();
    op(0, 0, 0, 0, 0, 1);
    op(1, 24'h400000, 0, 0, 0, 0);
    drain();
    chk("cfg_in_mac", last_out, 24'h200000);
    op(0, 0, 1, 8'd4, 24'h000000, 0);
    op(0, 0, 0, 0, 0, 1);
    op(1, 24'h400000, 0, 0, 0, 0);
    drain();
    chk("cfg_oob", last_out, 24'h200000);
    op(1, 24'h7FFFFF, 0, 0, 0, 0);
    op(1, 24'h400000, 0, 0, 0, 1);
    drain();
    chk("flush_in", last_out, 24'h200000);
    op(1, 24'h400000, 1, 8'd0, 24'h200000, 1);
    drain();
    chk("cfg_in", last_out, 24'h100000);
    op(0, 0, 1, 8'd0, 24'h400000, 0);

    op(0, 0, 0, 0, 0, 1);
    op(1, 24'h400000, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rmid_out_valid", out_valid, 0);
    chk("rmid_busy", busy, 0);
    exp_q.delete();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
    @(negedge clk);
    reset = 1'b1;
    impulse_seq("after_rst");

    for (int i = 0; i < 4; i++) op(0, 0, 1, 8'(i), 24'h7FFFFF, 0);
    op(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) op(1, 24'h7FFFFF, 0, 0, 0, 0);
    drain();
    chk("sat_pos_data", last_out, 24'h7FFFFF);
    chk("sat_pos_flag", last_sat, 1);
    for (int i = 0; i < 4; i++) op(1, 24'h800000, 0, 0, 0, 0);
    drain();
    chk("sat_neg_data", last_out, 24'h800000);
    chk("sat_neg_flag", last_sat, 1);

    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: op(0, 0, 0, 0, 0, 1);
        1: op(0, 0, 1, 8'($urandom_range(0, 5)), 24'($urandom), 0);
        2: op(1, 24'($urandom), 1, 8'($urandom_range(0, 5)),
              24'($urandom), 0);
        3: op(1, 24'($urandom), 0, 0, 0, 1);
        default: op(1, 24'($urandom), 0, 0, 0, 0);
      endcase
    end
    rdy_mode = 1;
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
